// File: rtl/mul_seq_n_bit.sv
// Sequential shift-add multiplier: one partial product per clock, signed or
// unsigned per operation, with a start/busy/done handshake.
module mul_seq_n_bit #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               sgn,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic [2*WIDTH-1:0] z,
  output logic               busy,
  output logic               done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   mcand_reg, mplier_reg;
  logic [2*WIDTH:0]   acc_reg, acc_next;
  logic [CW-1:0]      cnt_reg;
  logic               neg_reg;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   mag_x, mag_y;

  // Operands are reduced to magnitudes; the sign is reapplied once at the end.
  always_comb begin
    mag_x = (sgn && x[WIDTH-1]) ? -x : x;
    mag_y = (sgn && y[WIDTH-1]) ? -y : y;
  end

  // One shift-add step: optional add into the upper half, then shift right.
  always_comb begin
    sum = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, mcand_reg};
    if (mplier_reg[0])
      acc_next = {1'b0, sum, acc_reg[WIDTH-1:1]};
    else
      acc_next = acc_reg >> 1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (cnt_reg == LAST) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      neg_reg    <= 1'b0;
      z          <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            mcand_reg  <= mag_x;
            mplier_reg <= mag_y;
            neg_reg    <= sgn & (x[WIDTH-1] ^ y[WIDTH-1]);
            acc_reg    <= '0;
            cnt_reg    <= '0;
          end
        end
        CALC: begin
          acc_reg    <= acc_next;
          mplier_reg <= mplier_reg >> 1;
          cnt_reg    <= cnt_reg + 1'b1;
        end
        FIX: begin
          // Negating a zero magnitude yields zero, so no special case is needed.
          z    <= neg_reg ? -acc_reg[2*WIDTH-1:0] : acc_reg[2*WIDTH-1:0];
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_n_bit.sv
// Directed bench for mul_seq_n_bit: an 8-bit instance for handshake/timing
// cases and a 4-bit instance swept exhaustively in both modes.
module tb_mul_seq_n_bit;

  logic        clk = 1'b0;
  logic        rst;

  logic        start8 = 1'b0, sgn8 = 1'b0;
  logic [7:0]  x8 = '0, y8 = '0;
  logic [15:0] z8;
  logic        busy8, done8;

  logic        start4 = 1'b0, sgn4 = 1'b0;
  logic [3:0]  x4 = '0, y4 = '0;
  logic [7:0]  z4;
  logic        busy4, done4;

  int tests = 0;
  int fails = 0;
  int lat, bcnt, prod, ai, bi;
  bit zs, sawdone;
  logic [7:0] exp4;

  always #5 clk = ~clk;

  mul_seq_n_bit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sgn(sgn8), .x(x8), .y(y8),
    .z(z8), .busy(busy8), .done(done8)
  );

  mul_seq_n_bit #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .sgn(sgn4), .x(x4), .y(y4),
    .z(z4), .busy(busy4), .done(done4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one 8-bit operation; lat counts edges after the accepting edge.
  task automatic run8(input logic s, input logic [7:0] a, input logic [7:0] b,
                      output int l, output int bc, output bit zst);
    logic [15:0] z0;
    sgn8 = s; x8 = a; y8 = b; start8 = 1'b1;
    z0 = z8;
    tick();
    start8 = 1'b0;
    bc = busy8 ? 1 : 0;
    l = 0;
    zst = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      l++;
      if (done8) break;
      bc += busy8 ? 1 : 0;
      if (z8 !== z0) zst = 1'b0;
    end
  endtask

  task automatic run4(input logic s, input logic [3:0] a, input logic [3:0] b,
                      output int l);
    sgn4 = s; x4 = a; y4 = b; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    l = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      l++;
      if (done4) break;
    end
  endtask

  initial begin
    rst = 1'b0;
    #1 rst = 1'b1;
    #10;
    chk("reset_z", z8, 0);
    chk("reset_busy", busy8, 0);
    chk("reset_done", done8, 0);
    #1 rst = 1'b0;

    run8(1'b0, 8'd13, 8'd11, lat, bcnt, zs);
    chk("u13x11_latency", lat, 9);
    chk("u13x11_busy_cycles", bcnt, 9);
    chk("u13x11_z", z8, 16'h008F);
    chk("u13x11_z_stable", zs, 1);
    tick();
    chk("u13x11_done_drop", done8, 0);
    chk("u13x11_z_hold", z8, 16'h008F);

    run8(1'b0, 8'hFF, 8'hFF, lat, bcnt, zs);
    chk("u255x255_z", z8, 16'hFE01);
    chk("u255x255_z_stable", zs, 1);

    run8(1'b1, 8'hFD, 8'h05, lat, bcnt, zs);
    chk("s_m3x5_z", z8, 16'hFFF1);

    run8(1'b1, 8'h80, 8'h80, lat, bcnt, zs);
    chk("s_m128xm128_z", z8, 16'h4000);

    run8(1'b1, 8'h00, 8'hF9, lat, bcnt, zs);
    chk("s_0xm7_z", z8, 16'h0000);

    // START held high while operands churn during BUSY.
    sgn8 = 1'b0; x8 = 8'd13; y8 = 8'd11; start8 = 1'b1;
    tick();
    lat = 0;
    for (int k = 0; k < 40; k++) begin
      x8 = 8'($urandom);
      y8 = 8'($urandom);
      sgn8 = 1'($urandom);
      tick();
      lat++;
      if (done8) break;
    end
    chk("held_latency", lat, 9);
    chk("held_z", z8, 16'h008F);
    sgn8 = 1'b0; x8 = 8'd2; y8 = 8'd3;
    tick();
    start8 = 1'b0;
    lat = 1;
    for (int k = 0; k < 40; k++) begin
      tick();
      lat++;
      if (done8) break;
    end
    chk("b2b_done_spacing", lat, 10);
    chk("b2b_z", z8, 16'h0006);

    // Reset in the middle of an operation.
    sgn8 = 1'b0; x8 = 8'd13; y8 = 8'd11; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    #1;
    chk("midrst_z", z8, 0);
    chk("midrst_busy", busy8, 0);
    chk("midrst_done", done8, 0);
    #2 rst = 1'b0;
    sawdone = 1'b0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (done8) sawdone = 1'b1;
    end
    chk("midrst_no_done", sawdone, 0);
    run8(1'b0, 8'd2, 8'd3, lat, bcnt, zs);
    chk("postrst_latency", lat, 9);
    chk("postrst_z", z8, 16'h0006);

    run4(1'b0, 4'hF, 4'hF, lat);
    chk("w4_u15x15", z4, 8'hE1);
    run4(1'b1, 4'h8, 4'h8, lat);
    chk("w4_s_m8xm8", z4, 8'h40);
    chk("w4_latency", lat, 5);

    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          run4(1'(s), 4'(a), 4'(b), lat);
          ai = (s == 1 && a >= 8) ? a - 16 : a;
          bi = (s == 1 && b >= 8) ? b - 16 : b;
          prod = ai * bi;
          exp4 = 8'(prod);
          chk($sformatf("w4_sweep s=%0d x=%0d y=%0d", s, a, b), z4, exp4);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mul_seq_n_bit.md
# mul_seq_n_bit

Parametrised sequential shift-add multiplier: next generation of the team's combinational 4-bit multipliers. Operand width is set by a parameter, and signed or unsigned mode is selectable per operation. It runs one partial product per clock behind a START/BUSY/DONE handshake. Area is traded for latency in datapaths where a WIDTH×WIDTH array multiplier is too large.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32
- CLK  input  1  rising-edge clock
- RST  input  1  asynchronous, active-high reset
- START  input  1  request; sampled only while idle
- SGN  input  1  1 = two's-complement operands and product, 0 = unsigned; sampled with START
- X  input  WIDTH  multiplicand; sampled with START
- Y  input  WIDTH  multiplier; sampled with START
- Z  output  2*WIDTH  product; registered, holds value until next DONE
- BUSY  output  1  high from the accepting edge until the edge that raises DONE
- DONE  output  1  one-cycle pulse, Z valid in that cycle and after

## Operation
- States: IDLE, CALC, FIX.
- IDLE: BUSY=0. On a rising edge with START=1:
  - latch SGN;
  - load magnitudes |X| and |Y| into internal registers (SGN=0: raw values);
  - store neg = SGN & (X[MSB] ^ Y[MSB]);
  - clear the accumulator and the bit counter;
  - go to CALC.
- CALC: one iteration per edge, WIDTH iterations in total.
  - If multiplier-register LSB=1, add the multiplicand magnitude into the upper half of the 2*WIDTH+1-bit accumulator.
  - Shift accumulator and multiplier register right by 1.
  - Increment the counter.
  - After the WIDTH-th iteration, go to FIX.
- FIX: Z <= neg ? -acc : acc (2*WIDTH bits), DONE <= 1, go to IDLE.
- Width rules:
  - A magnitude of -2^(WIDTH-1) is 2^(WIDTH-1) and fits in WIDTH unsigned bits.
  - Maximum product magnitude is 2^(2*WIDTH-2) signed or (2^WIDTH-1)^2 unsigned. Both fit in 2*WIDTH bits, so there is no overflow in either mode.
  - Zero operand with neg=1 gives Z=0.
- START while BUSY=1 is ignored. It is neither queued nor does it disturb the operation; X, Y and SGN may change freely while BUSY.
- Z is unchanged from an accepting edge until the next DONE edge.

## Timing
- Reset (asynchronous, any state): state=IDLE, Z=0, BUSY=0, DONE=0, internal registers cleared. An in-flight operation is discarded, with no DONE.
- Edge E0 samples START=1 in IDLE: BUSY=1 after E0.
- CALC occupies edges E1..E_WIDTH.
- Edge E_(WIDTH+1) (FIX): Z updated, DONE=1, BUSY=0.
- Latency: DONE is high in the cycle after edge E0+WIDTH+1.
- DONE drops after the following edge unconditionally.
- START=1 in the DONE cycle is accepted at that edge. Back-to-back throughput is one result per WIDTH+2 cycles.
- Release of RST is taken as synchronous to CLK by the system; the first START is accepted on the first edge after release.

## Test plan
- WIDTH=8, SGN=0, X=13, Y=11, START pulse:
  - DONE exactly WIDTH+1=9 edges after the accepting edge, Z=0x008F.
  - BUSY high for those 9 cycles, DONE for 1.
- WIDTH=8, SGN=0, X=0xFF, Y=0xFF -> Z=0xFE01.
- WIDTH=8, SGN=1:
  - X=-3, Y=5 -> Z=0xFFF1.
  - X=-128, Y=-128 -> Z=0x4000.
  - X=0, Y=-7 -> Z=0x0000.
- WIDTH=8, START held high with changing X/Y during BUSY: only the first operands are used, result 13*11=0x008F. A new START in the DONE cycle is accepted, second DONE 10 cycles later.
- Assert RST at iteration 4 of an operation:
  - Z=0, BUSY=0, DONE=0 immediately (asynchronous), with no DONE afterwards.
  - A subsequent X=2, Y=3 gives Z=6.
- WIDTH=4 instance:
  - exhaustive sweep of all 256 operand pairs in both SGN modes, compared against a behavioral product;
  - spot checks: 15*15=0xE1 unsigned, -8*-8=0x40 signed.
